// File: rtl/shift_ctrl_pkg.sv
// Shared constants for the shift sequencer: funct codes, FSM states, shift-op encoding and
// the funct decoder.
package shift_ctrl_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_LEFT        = 2'd0;
  localparam logic [1:0] OP_RIGHT_LOG   = 2'd1;
  localparam logic [1:0] OP_RIGHT_ARITH = 2'd2;

  typedef struct packed {
    logic       legal;
    logic       var_amt;
    logic [1:0] op;
  } decode_t;

  function automatic decode_t decode_funct(input logic [5:0] funct);
    decode_t d;
    d = '{legal: 1'b1, var_amt: 1'b0, op: OP_LEFT};
    case (funct)
      FUNCT_SLL:  d.op = OP_LEFT;
      FUNCT_SRL:  d.op = OP_RIGHT_LOG;
      FUNCT_SRA:  d.op = OP_RIGHT_ARITH;
      FUNCT_SLLV: begin d.op = OP_LEFT;        d.var_amt = 1'b1; end
      FUNCT_SRLV: begin d.op = OP_RIGHT_LOG;   d.var_amt = 1'b1; end
      FUNCT_SRAV: begin d.op = OP_RIGHT_ARITH; d.var_amt = 1'b1; end
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_ctrl_step.sv
// Combinational one-bit shifter used once per SHIFT cycle.
module shift_ctrl_step
  import shift_ctrl_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_LEFT:        data_o = {data_i[30:0], 1'b0};
      OP_RIGHT_LOG:   data_o = {1'b0, data_i[31:1]};
      OP_RIGHT_ARITH: data_o = {data_i[31], data_i[31:1]};
      default:        data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_ctrl.sv
// Iterative shift sequencer: decodes funct on start, loads the mux operand, shifts one bit
// per cycle and pulses done (with illegal for non-shift functs).
module shift_ctrl
  import shift_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic        src_a,
  input  logic [31:0] reg_A_data,
  input  logic [31:0] shift_src_data,
  output logic        shift_src_sel,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] result
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  amt_q, amt_d;
  logic [1:0]  op_q, op_d;
  logic        ill_q, ill_d;
  logic        sel_q, sel_d;
  logic [31:0] result_q, result_d;
  logic [31:0] step_out;
  decode_t     dec;

  // Only the low five bits of the A register carry a shift amount.
  logic unused_reg_a;
  assign unused_reg_a = ^reg_A_data[31:5];

  shift_ctrl_step u_step (
    .op_i   (op_q),
    .data_i (result_q),
    .data_o (step_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    amt_d    = amt_q;
    op_d     = op_q;
    ill_d    = ill_q;
    sel_d    = sel_q;
    result_d = result_q;
    dec      = decode_funct(funct);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = ~src_a;
          op_d    = dec.op;
          amt_d   = dec.var_amt ? reg_A_data[4:0] : shamt;
          ill_d   = ~dec.legal;
          state_d = dec.legal ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        result_d = shift_src_data;
        cnt_d    = amt_q;
        state_d  = (amt_q == 5'd0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        result_d = step_out;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      amt_q    <= 5'd0;
      op_q     <= OP_LEFT;
      ill_q    <= 1'b0;
      sel_q    <= 1'b1;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      amt_q    <= amt_d;
      op_q     <= op_d;
      ill_q    <= ill_d;
      sel_q    <= sel_d;
      result_q <= result_d;
    end
  end

  assign shift_src_sel = sel_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign illegal       = (state_q == ST_DONE) & ill_q;
  assign result        = result_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Scoreboard bench for shift_ctrl: driver pushes model-predicted completions, monitor checks
// every done pulse for value, flags, select and timing.
module tb_shift_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [4:0]  shamt = 5'd0;
  logic        src_a = 1'b0;
  logic [31:0] reg_A_data = 32'd0;
  logic [31:0] shift_src_data = 32'd0;
  logic        shift_src_sel;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    logic        sel;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_res = 32'd0;
  logic        model_sel = 1'b1;
  logic [5:0]  legal_functs [6] = '{6'b000000, 6'b000010, 6'b000011,
                                    6'b000100, 6'b000110, 6'b000111};

  shift_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .funct          (funct),
    .shamt          (shamt),
    .src_a          (src_a),
    .reg_A_data     (reg_A_data),
    .shift_src_data (shift_src_data),
    .shift_src_sel  (shift_src_sel),
    .busy           (busy),
    .done           (done),
    .illegal        (illegal),
    .result         (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] f);
    foreach (legal_functs[i]) if (legal_functs[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: whole-word shift by n using language operators.
  function automatic logic [31:0] ref_shift(input logic [5:0] f, input int n,
                                            input logic [31:0] d);
    logic signed [31:0] s;
    s = d;
    if (f == 6'b000000 || f == 6'b000100) return d << n;
    if (f == 6'b000010 || f == 6'b000110) return d >> n;
    return s >>> n;
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [4:0] sh, input logic sa,
                        input logic [31:0] ra, input logic [31:0] sd, input bit repulse);
    exp_t e;
    int   n;
    int   c0;
    bit   leg;
    bit   got;
    @(negedge clk);
    funct = f; shamt = sh; src_a = sa; reg_A_data = ra; shift_src_data = sd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
    leg = is_legal(f);
    n = f[2] ? int'(ra[4:0]) : int'(sh);
    model_sel = ~sa;
    if (leg) model_res = ref_shift(f, n, sd);
    e.res = model_res; e.ill = ~leg; e.sel = model_sel; e.cyc = leg ? c0 + n + 1 : c0;
    sb.push_back(e);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("sel_after_start", {31'd0, shift_src_sel}, {31'd0, ~sa});
    // Request fields need only be valid at the start edge.
    funct = 6'($urandom); shamt = 5'($urandom); src_a = 1'($urandom); reg_A_data = $urandom;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
      chk("busy_mid_op", {31'd0, busy}, 32'd1);
      if (i == 1) shift_src_data = $urandom;
      if (repulse && i == 2) start = 1'b1;
    end
    if (!got) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL done_timeout: no done within 40 cycles for funct %b", f);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (illegal && !done) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL illegal_without_done: illegal=1 done=0 at t=%0t", $time);
      end
      if (done) begin
        if (sb.size() == 0) begin
          total = total + 1;
          bad = bad + 1;
          $display("FAIL unexpected_done: done=1 with nothing outstanding at t=%0t", $time);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
          chk("shift_src_sel", {31'd0, shift_src_sel}, {31'd0, e.sel});
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] f;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_sel", {31'd0, shift_src_sel}, 32'd1);

    run_op(6'b000000, 5'd4, 1'b0, 32'h0, 32'h0000_0001, 1'b0);
    run_op(6'b000111, 5'd3, 1'b0, 32'h0000_001F, 32'h8000_0000, 1'b0);
    run_op(6'b000010, 5'd0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    run_op(6'b100000, 5'd7, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
    run_op(6'b000100, 5'd1, 1'b0, 32'h0000_0008, 32'h1234_5678, 1'b1);
    run_op(6'b000010, 5'd3, 1'b1, 32'h0, 32'hF000_000F, 1'b0);

    // Abort an SRA by 10 partway through SHIFT.
    @(negedge clk);
    funct = 6'b000011; shamt = 5'd10; src_a = 1'b1; shift_src_data = 32'h8000_00F0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_res = 32'd0;
    model_sel = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_sel", {31'd0, shift_src_sel}, 32'd1);
    repeat (20) @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 6) == 0) begin
        f = 6'($urandom);
        while (is_legal(f)) f = 6'($urandom);
      end else begin
        f = legal_functs[$urandom_range(0, 5)];
      end
      run_op(f, 5'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
